// File: rtl/life_grid_scanner.sv
// life_grid_scanner: double-buffered 8x8 Life board display.
// Accepts generations over a valid/ready handshake into a shadow buffer.
// Row-scans the active buffer onto an LED matrix, with one blank cycle after
// each lit row. A pending board is swapped in only on the final blank cycle
// of a frame, so a frame never mixes two generations.
module life_grid_scanner #(
    // Clocks each row stays lit per frame; must be 1..255.
    parameter int unsigned DWELL = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] grid_in,
    input  logic        grid_valid,
    output logic        grid_ready,
    output logic [7:0]  row_sel,
    output logic [7:0]  col_data,
    output logic        frame_done,
    output logic        still_life,
    output logic        extinct,
    output logic [15:0] gen_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } state_t;

    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

    state_t      state_q, state_d;
    logic [63:0] active_q, active_d;
    logic [63:0] shadow_q, shadow_d;
    logic        shadow_full_q, shadow_full_d;
    logic [2:0]  row_q, row_d;
    logic [7:0]  dwell_q, dwell_d;
    logic [15:0] gen_count_q, gen_count_d;
    logic        still_life_q, still_life_d;

    logic        transfer;
    logic [63:0] active_shifted;

    // Decode all outputs from registered state only; grid_ready never looks at grid_valid.
    always_comb begin
        grid_ready     = (state_q == IDLE) ? 1'b1 : ~shadow_full_q;
        // Shift the lit row into the top byte; row 0 is the most significant byte.
        active_shifted = active_q << {row_q, 3'b000};
        row_sel        = 8'h00;
        col_data       = 8'h00;
        if (state_q == SHOW) begin
            row_sel  = 8'h01 << row_q;
            col_data = active_shifted[63:56];
        end
        frame_done = (state_q == BLANK) && (row_q == 3'd7);
        extinct    = (state_q != IDLE) && (active_q == 64'h0);
        still_life = still_life_q;
        gen_count  = gen_count_q;
    end

    // Next-state logic: handshake, shadow capture, row/dwell sequencing, frame swap.
    always_comb begin
        // NOTE: every _d starts as its _q so no path through the case below infers a latch.
        state_d       = state_q;
        active_d      = active_q;
        shadow_d      = shadow_q;
        shadow_full_d = shadow_full_q;
        row_d         = row_q;
        dwell_d       = dwell_q;
        gen_count_d   = gen_count_q;
        still_life_d  = still_life_q;

        transfer = grid_valid & grid_ready;

        if (transfer && (gen_count_q != 16'hFFFF)) begin
            gen_count_d = gen_count_q + 16'd1;
        end

        // Once scanning, every accepted board parks in the shadow buffer.
        // A swap only happens with shadow_full set, which holds grid_ready low,
        // so capture and swap never collide.
        if (transfer && (state_q != IDLE)) begin
            shadow_d      = grid_in;
            shadow_full_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (transfer) begin
                    active_d     = grid_in;
                    state_d      = SHOW;
                    row_d        = 3'd0;
                    dwell_d      = 8'd0;
                    still_life_d = 1'b0;
                end
            end
            SHOW: begin
                if (dwell_q == DWELL_LAST) begin
                    state_d = BLANK;
                    dwell_d = 8'd0;
                end else begin
                    dwell_d = dwell_q + 8'd1;
                end
            end
            BLANK: begin
                state_d = SHOW;
                // Row 7 wraps to 0 naturally in 3 bits.
                row_d   = row_q + 3'd1;
                if ((row_q == 3'd7) && shadow_full_q) begin
                    active_d      = shadow_q;
                    shadow_full_d = 1'b0;
                    still_life_d  = (shadow_q == active_q);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset; board buffers are cleared too.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so every flop samples pre-edge values.
        if (!reset) begin
            state_q       <= IDLE;
            active_q      <= 64'h0;
            shadow_q      <= 64'h0;
            shadow_full_q <= 1'b0;
            row_q         <= 3'd0;
            dwell_q       <= 8'd0;
            gen_count_q   <= 16'h0000;
            still_life_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            active_q      <= active_d;
            shadow_q      <= shadow_d;
            shadow_full_q <= shadow_full_d;
            row_q         <= row_d;
            dwell_q       <= dwell_d;
            gen_count_q   <= gen_count_d;
            still_life_q  <= still_life_d;
        end
    end

endmodule
